// File: rtl/lutram_request_controller_pkg.sv
// Shared definitions for the LUTRAM request controller.
//   BYTE_LEN_IN_BITS : width of one write-mask byte lane
//   ctrl_state_e     : controller state (zero sweep / normal traffic)
package lutram_request_controller_pkg;

   localparam int unsigned BYTE_LEN_IN_BITS = 8;

   typedef enum logic {
      INIT = 1'b0,
      IDLE = 1'b1
   } ctrl_state_e;

endpackage

// File: rtl/lutram_request_controller.sv
// Initiator-side controller for a single-port, byte-masked, async-read LUTRAM.
// After reset it sweeps every set to zero, then serves valid/ready requests
// (all-zero mask = read, otherwise byte-masked write) and returns read data on
// a valid/ready response channel one cycle after the read is accepted.
//
// Ports:
//   clk_in, reset_in          clock, synchronous active-high reset
//   request_*                 request channel (valid/ready, mask, addr, data)
//   response_*                read-response channel (valid/ready, data)
//   init_done_out             zero sweep complete, requests may be accepted
//   mem_*_out                 drive the LUTRAM storage port
//   mem_read_entry_in         combinational read data from the LUTRAM
module lutram_request_controller
   import lutram_request_controller_pkg::*;
#(
   parameter int unsigned SINGLE_ENTRY_SIZE_IN_BITS = 64,
   parameter int unsigned NUM_SET                   = 64,
   parameter int unsigned SET_PTR_WIDTH_IN_BITS     = $clog2(NUM_SET),
   parameter int unsigned WRITE_MASK_LEN            = SINGLE_ENTRY_SIZE_IN_BITS / BYTE_LEN_IN_BITS
) (
   input  logic                                 clk_in,
   input  logic                                 reset_in,

   input  logic                                 request_valid_in,
   output logic                                 request_ready_out,
   input  logic [WRITE_MASK_LEN-1:0]            request_write_mask_in,
   input  logic [SET_PTR_WIDTH_IN_BITS-1:0]     request_addr_in,
   input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] request_data_in,

   output logic                                 response_valid_out,
   input  logic                                 response_ready_in,
   output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] response_data_out,

   output logic                                 init_done_out,

   output logic                                 mem_access_en_out,
   output logic [WRITE_MASK_LEN-1:0]            mem_write_en_out,
   output logic [SET_PTR_WIDTH_IN_BITS-1:0]     mem_set_addr_out,
   output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] mem_write_entry_out,
   input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] mem_read_entry_in
);

   localparam logic [SET_PTR_WIDTH_IN_BITS-1:0] LAST_SET = SET_PTR_WIDTH_IN_BITS'(NUM_SET - 1);

   ctrl_state_e                          state_q,      state_d;
   logic [SET_PTR_WIDTH_IN_BITS-1:0]     init_ptr_q,   init_ptr_d;
   logic                                 init_done_q,  init_done_d;
   logic                                 resp_valid_q, resp_valid_d;
   logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] resp_data_q,  resp_data_d;

   logic ready;
   logic accept;

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         state_q      <= INIT;
         init_ptr_q   <= '0;
         init_done_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         init_ptr_q   <= init_ptr_d;
         init_done_q  <= init_done_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
      end
   end

   always_comb begin
      state_d             = state_q;
      init_ptr_d          = init_ptr_q;
      init_done_d         = init_done_q;
      resp_valid_d        = resp_valid_q;
      resp_data_d         = resp_data_q;
      ready               = 1'b0;
      accept              = 1'b0;
      mem_access_en_out   = 1'b0;
      mem_write_en_out    = '0;
      mem_set_addr_out    = request_addr_in;
      mem_write_entry_out = request_data_in;

      unique case (state_q)
         INIT: begin
            // Zero-fill one set per cycle; all lanes written.
            mem_access_en_out   = 1'b1;
            mem_write_en_out    = '1;
            mem_set_addr_out    = init_ptr_q;
            mem_write_entry_out = '0;
            init_ptr_d          = init_ptr_q + 1'b1;
            if (init_ptr_q == LAST_SET) begin
               state_d     = IDLE;
               init_done_d = 1'b1;
            end
         end
         IDLE: begin
            // A slot is free if nothing is held or the held response leaves now.
            ready             = !resp_valid_q || response_ready_in;
            accept            = request_valid_in && ready;
            mem_access_en_out = accept;
            mem_write_en_out  = accept ? request_write_mask_in : '0;
            if (resp_valid_q && response_ready_in) begin
               resp_valid_d = 1'b0;
            end
            // A read accepted alongside a handshake reloads the slot.
            if (accept && (request_write_mask_in == '0)) begin
               resp_valid_d = 1'b1;
               resp_data_d  = mem_read_entry_in;
            end
         end
      endcase
   end

   assign request_ready_out  = ready;
   assign response_valid_out = resp_valid_q;
   assign response_data_out  = resp_data_q;
   assign init_done_out      = init_done_q;

endmodule
